ex_mem_skid_reg: RTL and testbench

EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

---
 rtl/ex_mem_skid_reg.sv | 130 +++++++++++++
 tb/tb_ex_mem_skid_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_skid_reg
// Description : EX/MEM pipeline register built as a two-entry skid buffer.
//               HEAD drives the MEM-side outputs and SKID catches one extra
//               beat, so in_ready depends only on registered state.
//               Bubbles present an all-zero control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int LOAD_W = 6,
    parameter int CTRL_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    // EX side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] rdata2_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [LOAD_W-1:0] load_in,
    // MEM side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] rdata2_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [LOAD_W-1:0] load_out,
    // Forwarding / status
    output logic              fwd_en,
    output logic [1:0]        occupancy
);

    // One stored entry: {ctrl, alu, rdata2, dest, load}
    localparam int ENT_W = CTRL_W + 2 * DATA_W + DEST_W + LOAD_W;

    // RegWrite position inside the control bundle
    localparam int REGWRITE_BIT = 2;

    // State value equals the number of held entries
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   head_q, head_d;
    logic [ENT_W-1:0]   skid_q, skid_d;

    logic [ENT_W-1:0]   w_beat;
    logic [CTRL_W-1:0]  w_head_ctrl;
    logic               w_push;
    logic               w_pop;

    assign w_beat = {ctrl_in, alu_in, rdata2_in, dest_in, load_in};

    // Handshake status comes purely from registered state (no out_ready path)
    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign occupancy = state_q;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    assign {w_head_ctrl, alu_out, rdata2_out, dest_out, load_out} = head_q;

    // A bubble must not carry any write/branch/fin side effects
    assign ctrl_out = out_valid ? w_head_ctrl : '0;
    assign fwd_en   = out_valid & w_head_ctrl[REGWRITE_BIT];

    // Next-state and entry movement; flush overrides any handshake
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (w_push) begin
                        state_d = S_ONE;
                        head_d  = w_beat;
                    end
                end
                S_ONE: begin
                    if (w_push && !w_pop) begin
                        state_d = S_FULL;
                        skid_d  = w_beat;
                    end else if (w_pop && !w_push) begin
                        state_d = S_EMPTY;
                    end else if (w_push && w_pop) begin
                        head_d  = w_beat;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        state_d = S_ONE;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers; reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_skid_reg
// Description : Self-checking bench for ex_mem_skid_reg. A queue-based FIFO
//               model predicts every output; directed sequences pin literal
//               values, then a randomized run exercises push/pop/flush mixes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid_reg;

    typedef struct packed {
        logic [6:0]  c;
        logic [31:0] a;
        logic [31:0] r;
        logic [4:0]  d;
        logic [5:0]  l;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  ctrl_in = '0;
    logic [31:0] alu_in = '0;
    logic [31:0] rdata2_in = '0;
    logic [4:0]  dest_in = '0;
    logic [5:0]  load_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  ctrl_out;
    logic [31:0] alu_out;
    logic [31:0] rdata2_out;
    logic [4:0]  dest_out;
    logic [5:0]  load_out;
    logic        fwd_en;
    logic [1:0]  occupancy;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Reference model: list of held beats, oldest first
    ent_t q[$];
    ent_t last_head = '0;

    ex_mem_skid_reg #(
        .DATA_W(32), .DEST_W(5), .LOAD_W(6), .CTRL_W(7)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .alu_in(alu_in), .rdata2_in(rdata2_in),
        .dest_in(dest_in), .load_in(load_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .alu_out(alu_out), .rdata2_out(rdata2_out),
        .dest_out(dest_out), .load_out(load_out),
        .fwd_en(fwd_en), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one beat's worth of inputs, advance one edge, update the model
    task automatic cycle(input logic v, input logic rdy, input logic fl, input ent_t e);
        bit push;
        bit pop;
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
        {ctrl_in, alu_in, rdata2_in, dest_in, load_in} = e;
        @(posedge clk);
        push = v && (q.size() < 2);
        pop  = rdy && (q.size() > 0);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        if (q.size() > 0) last_head = q[0];
        #1;
    endtask

    task automatic do_reset();
        cmp_en    = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        last_head = '0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_alu_out", 64'(alu_out), 64'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;
    endtask

    function automatic ent_t mk(input logic [6:0] c, input logic [31:0] a);
        ent_t e;
        e.c = c;
        e.a = a;
        e.r = a ^ 32'h5A5A_0000;
        e.d = a[4:0];
        e.l = a[5:0];
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.c = 7'($urandom);
        e.a = $urandom;
        e.r = $urandom;
        e.d = 5'($urandom);
        e.l = 6'($urandom);
        return e;
    endfunction

    // Compare every output against the model midway through each cycle
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            ent_t h;
            bit   ov;
            ov = (q.size() > 0);
            h  = ov ? q[0] : last_head;
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(ov));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("ctrl_out", 64'(ctrl_out), ov ? 64'(h.c) : 64'd0);
            chk("alu_out", 64'(alu_out), 64'(h.a));
            chk("rdata2_out", 64'(rdata2_out), 64'(h.r));
            chk("dest_out", 64'(dest_out), 64'(h.d));
            chk("load_out", 64'(load_out), 64'(h.l));
            chk("fwd_en", 64'(fwd_en), 64'(ov && h.c[2]));
        end
    end

    initial begin
        do_reset();

        // Streaming with out_ready held high
        cycle(1, 1, 0, mk(7'h04, 32'h10));
        chk("stream_v0", 64'(out_valid), 64'd1);
        chk("stream_a0", 64'(alu_out), 64'h10);
        cycle(1, 1, 0, mk(7'h04, 32'h11));
        chk("stream_a1", 64'(alu_out), 64'h11);
        cycle(1, 1, 0, mk(7'h04, 32'h12));
        chk("stream_a2", 64'(alu_out), 64'h12);
        chk("stream_occ", 64'(occupancy), 64'd1);
        cycle(0, 1, 0, '0);
        chk("stream_drain", 64'(out_valid), 64'd0);

        // Stall then drain
        cycle(1, 0, 0, mk(7'h00, 32'hA));
        cycle(1, 0, 0, mk(7'h00, 32'hB));
        chk("stall_occ", 64'(occupancy), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_head", 64'(alu_out), 64'hA);
        cycle(0, 1, 0, '0);
        chk("stall_pop1", 64'(alu_out), 64'hB);
        chk("stall_ready1", 64'(in_ready), 64'd1);
        cycle(0, 1, 0, '0);
        chk("stall_empty", 64'(occupancy), 64'd0);

        // Simultaneous push and pop while holding one entry
        cycle(1, 0, 0, mk(7'h00, 32'h5));
        cycle(1, 1, 0, mk(7'h00, 32'h6));
        chk("pushpop_alu", 64'(alu_out), 64'h6);
        chk("pushpop_occ", 64'(occupancy), 64'd1);

        // Flush while full, with a beat offered in the same cycle
        cycle(1, 0, 0, mk(7'h04, 32'h7));
        chk("pre_flush_occ", 64'(occupancy), 64'd2);
        cycle(1, 0, 1, mk(7'h04, 32'h8));
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_ov", 64'(out_valid), 64'd0);
        chk("flush_ctrl", 64'(ctrl_out), 64'd0);
        cycle(0, 1, 0, '0);
        chk("flush_dropped", 64'(occupancy), 64'd0);

        // Asynchronous reset in the middle of a stall
        cycle(1, 0, 0, mk(7'h04, 32'h99));
        chk("pre_rst_fwd", 64'(fwd_en), 64'd1);
        #2;
        cmp_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("arst_fwd", 64'(fwd_en), 64'd0);
        chk("arst_ctrl", 64'(ctrl_out), 64'd0);
        chk("arst_alu", 64'(alu_out), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        do_reset();

        // Bubble after a RegWrite|MemWrite beat drains
        cycle(1, 1, 0, mk(7'h14, 32'h42));
        chk("bubble_fwd1", 64'(fwd_en), 64'd1);
        chk("bubble_ctrl1", 64'(ctrl_out), 64'h14);
        cycle(0, 1, 0, '0);
        chk("bubble_ctrl0", 64'(ctrl_out), 64'h00);
        chk("bubble_fwd0", 64'(fwd_en), 64'd0);
        chk("bubble_hold", 64'(alu_out), 64'h42);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 31) == 0), rnd_ent());
        end
        cycle(0, 1, 0, '0);
        cycle(0, 1, 0, '0);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
